// File: rtl/ram_pkg.sv
// ram_pkg: shared FSM state, geometry constants and clog2 helper for the banked RAM
package ram_pkg;
  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam int DFFRAM_COLS = 4;
  localparam int DFFRAM_AW = 10;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/ram_init_seq.sv
// ram_init_seq: post-reset zero-fill sequencer producing fill address and ready
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int BANK_AW = DFFRAM_AW,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  output logic fill_active,
  output logic [BANK_AW-1:0] fill_addr,
  output logic ready
);
  state_t state_q, state_d;
  logic [BANK_AW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT_ZERO ? S_INIT : S_RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    fill_active = state_q == S_INIT;
    ready = (state_q == S_RUN) & rst_n;
    fill_addr = cnt_q;
    cnt_d = fill_active ? cnt_q + 1'b1 : cnt_q;
    state_d = (fill_active && &cnt_q) ? S_RUN : state_q;
  end
endmodule

// File: rtl/ram_banked_init.sv
// ram_banked_init: multi-bank single-port RAM with flat decode, registered read mux and zero-fill
module ram_banked_init
  import ram_pkg::*;
#(
  parameter int BANKS = 5,
  parameter int BANK_AW = DFFRAM_AW,
  parameter int COLS = DFFRAM_COLS,
  parameter bit INIT_ZERO = 1'b1,
  localparam int DW = 8 * COLS,
  localparam int SEL_W = (clog2(BANKS) < 1) ? 1 : clog2(BANKS),
  localparam int AW = BANK_AW + SEL_W
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic EN,
  input  logic [COLS-1:0] WE,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] Di,
  output logic [DW-1:0] Do,
  output logic DO_VALID,
  output logic ERR,
  output logic READY
);
  logic fill_active;
  logic [BANK_AW-1:0] fill_addr;
  logic [SEL_W-1:0] bank, rd_sel_q, rd_sel_d;
  logic rd_pend_q, rd_pend_d, err_q, err_d, acc, in_range;
  logic [BANK_AW-1:0] m_a;
  logic [COLS-1:0] m_we;
  logic [DW-1:0] m_di, lane_mask;
  logic [BANKS-1:0] m_en;
  logic [DW-1:0] m_do [BANKS];
  ram_init_seq #(.BANK_AW(BANK_AW), .INIT_ZERO(INIT_ZERO)) u_seq (
    .clk(CLK),
    .rst_n(RSTn),
    .fill_active(fill_active),
    .fill_addr(fill_addr),
    .ready(READY)
  );
  always_comb begin
    bank = A[AW-1:BANK_AW];
    in_range = {1'b0, bank} < (SEL_W + 1)'(BANKS);
    acc = READY & EN;
    m_a = fill_active ? fill_addr : A[BANK_AW-1:0];
    m_we = fill_active ? '1 : WE;
    m_di = fill_active ? '0 : Di;
    for (int k = 0; k < COLS; k++) lane_mask[8*k +: 8] = {8{m_we[k]}};
    for (int i = 0; i < BANKS; i++) m_en[i] = fill_active | (acc & in_range & (bank == SEL_W'(i)));
    rd_pend_d = acc & ~|WE;
    err_d = acc & ~in_range;
    rd_sel_d = in_range ? bank : '0;
    Do = (rd_pend_q & ~err_q) ? m_do[rd_sel_q] : '0;
    DO_VALID = rd_pend_q;
    ERR = err_q;
  end
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      rd_sel_q <= '0;
      rd_pend_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rd_sel_q <= rd_sel_d;
      rd_pend_q <= rd_pend_d;
      err_q <= err_d;
    end
  end
  for (genvar i = 0; i < BANKS; i++) begin : g_bank
`ifdef DFFRAM_HARD_MACRO
    DFFRAM #(.WORDS(2**BANK_AW), .WSIZE(COLS)) u_ram (
      .CLK(CLK),
      .WE0(m_we),
      .EN0(m_en[i]),
      .A0(m_a),
      .Di0(m_di),
      .Do0(m_do[i])
    );
`else
    logic [DW-1:0] mem [2**BANK_AW];
    logic [DW-1:0] do_q;
    always_ff @(posedge CLK) begin
      if (m_en[i]) begin
        mem[m_a] <= (mem[m_a] & ~lane_mask) | (m_di & lane_mask);
        do_q <= mem[m_a];
      end
    end
    assign m_do[i] = do_q;
`endif
  end
endmodule
